burst_req_gen: RTL

- Upstream driver for the grant generator. The grant generator answers a one-cycle req plus num_grants with N consecutive gnt cycles, and flags the Nth with last.
- burst_req_gen queues burst commands from a client in a small FIFO and issues them one at a time as req/num_grants pulses, only when the grant generator is idle.
- It tracks the returning gnt/last stream, reports completion per burst, and flags protocol violations.

---
 rtl/burst_pkg.sv | 28 ++
 rtl/burst_cmd_fifo.sv | 53 +++++
 rtl/burst_req_gen.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/burst_pkg.sv
// Shared types, constants and length helpers for the burst request generator.
package burst_pkg;

    localparam int MAX_BURST = 8;
    localparam int LEN_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACTIVE
    } state_t;

    // The grant generator encodes a full burst of MAX_BURST as zero.
    function automatic logic [2:0] len_to_num_grants(input logic [LEN_W-1:0] len);
        logic [2:0] ng;
        if (len == LEN_W'(MAX_BURST)) begin
            ng = 3'd0;
        end else begin
            ng = len[2:0];
        end
        return ng;
    endfunction

    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(MAX_BURST));
    endfunction

endpackage

// File: rtl/burst_cmd_fifo.sv
// Synchronous command FIFO holding burst lengths; pointers carry an extra wrap bit.
module burst_cmd_fifo
    import burst_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [LEN_W-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [LEN_W-1:0] o_head
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [LEN_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/burst_req_gen.sv
// Queues burst commands and issues them to the grant generator, checking the gnt/last stream.
// Optional stats counters are built when BURST_REQ_GEN_STATS_EN is defined.
module burst_req_gen
    import burst_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [LEN_W-1:0] i_cmd_len,
    output logic             o_req,
    output logic [2:0]       o_num_grants,
    input  logic             i_gnt,
    input  logic             i_last,
    output logic             o_done,
    output logic [LEN_W-1:0] o_done_len,
    output logic             o_bad_cmd,
    output logic             o_err,
    output logic             o_err_sticky
`ifdef BURST_REQ_GEN_STATS_EN
    ,
    output logic [15:0]      o_burst_cnt,
    output logic [19:0]      o_beat_cnt
`endif
);

    state_t           r_state;
    state_t           w_state_d;
    logic [LEN_W-1:0] r_cur_len;
    logic [LEN_W-1:0] w_cur_len_d;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_d;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [2:0]       r_num_grants;
    logic [2:0]       w_num_grants_d;
    logic             r_done;
    logic [LEN_W-1:0] r_done_len;
    logic             r_bad_cmd;
    logic             r_err;
    logic             r_err_sticky;

    logic             w_accept;
    logic             w_push;
    logic             w_bad_set;
    logic             w_pop;
    logic             w_done_set;
    logic             w_err_set;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [LEN_W-1:0] w_head;

    burst_cmd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (i_cmd_len),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // Illegal lengths are still handshaken so the client never stalls on them.
    assign o_cmd_ready = !w_fifo_full;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_push      = w_accept && len_legal(i_cmd_len);
    assign w_bad_set   = w_accept && !len_legal(i_cmd_len);

    assign w_cnt_inc = (r_cnt < LEN_W'(MAX_BURST)) ? (r_cnt + LEN_W'(1)) : r_cnt;

    always_comb begin
        w_state_d      = r_state;
        w_cur_len_d    = r_cur_len;
        w_cnt_d        = r_cnt;
        w_num_grants_d = r_num_grants;
        w_pop          = 1'b0;
        w_done_set     = 1'b0;
        w_err_set      = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (i_gnt) begin
                    w_err_set = 1'b1;
                end else if (!w_fifo_empty) begin
                    w_pop          = 1'b1;
                    w_cur_len_d    = w_head;
                    w_num_grants_d = len_to_num_grants(w_head);
                    w_state_d      = REQ;
                end
            end
            REQ: begin
                w_err_set = i_gnt;
                w_cnt_d   = '0;
                w_state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!i_gnt) begin
                    w_err_set = 1'b1;
                    w_state_d = IDLE;
                end else if (i_last && (w_cnt_inc == r_cur_len)) begin
                    w_done_set = 1'b1;
                    w_state_d  = IDLE;
                end else if (i_last || (w_cnt_inc == r_cur_len)) begin
                    w_err_set = 1'b1;
                    w_state_d = IDLE;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_cur_len    <= '0;
            r_cnt        <= '0;
            r_num_grants <= '0;
        end else begin
            r_state      <= w_state_d;
            r_cur_len    <= w_cur_len_d;
            r_cnt        <= w_cnt_d;
            r_num_grants <= w_num_grants_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_done       <= 1'b0;
            r_done_len   <= '0;
            r_bad_cmd    <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_done    <= w_done_set;
            r_bad_cmd <= w_bad_set;
            r_err     <= w_err_set;
            if (w_done_set) begin
                r_done_len <= r_cur_len;
            end
            if (w_err_set) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign o_req        = (r_state == REQ);
    assign o_num_grants = r_num_grants;
    assign o_done       = r_done;
    assign o_done_len   = r_done_len;
    assign o_bad_cmd    = r_bad_cmd;
    assign o_err        = r_err;
    assign o_err_sticky = r_err_sticky;

`ifdef BURST_REQ_GEN_STATS_EN
    logic [15:0] r_burst_cnt;
    logic [19:0] r_beat_cnt;
    logic [20:0] w_beat_sum;

    assign w_beat_sum = {1'b0, r_beat_cnt} + 21'(r_cur_len);

    // Burst count wraps; beat total saturates.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
        end else if (w_done_set) begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
            r_beat_cnt  <= w_beat_sum[20] ? '1 : w_beat_sum[19:0];
        end
    end

    assign o_burst_cnt = r_burst_cnt;
    assign o_beat_cnt  = r_beat_cnt;
`endif

endmodule
